gemm_tile_sequencer: RTL and testbench



---
 rtl/gemm_tile_sequencer_pkg.sv | 44 ++++
 rtl/gemm_tile_sequencer_if.sv | 36 +++
 rtl/gemm_phase_counter.sv | 31 +++
 rtl/gemm_tile_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_gemm_tile_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gemm_tile_sequencer_pkg.sv
// Shared GEMM tile configuration: array geometry, sequencer states, and the
// array mode / operand-mux decode reused by other GEMM blocks.
package gemm_tile_sequencer_pkg;

  localparam logic [4:0] SMALL_SYS_ROWS = 5'd8;
  localparam logic [4:0] SMALL_SYS_COLS = 5'd8;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    LOAD_W,
    FEED,
    DRAIN,
    DONE
  } gemm_state_t;

  typedef enum logic [1:0] {
    MODE_WIDE      = 2'b00,
    MODE_VERTICAL  = 2'b01,
    MODE_TALL_WIDE = 2'b10,
    MODE_TALL      = 2'b11
  } gemm_mode_t;

  typedef struct packed {
    gemm_mode_t mode;
    logic       if_mux_sel;
    logic       w_mux_sel;
  } gemm_cfg_t;

  // Tall: reduction depth fits the small array rows; Wide: outputs overflow its columns.
  function automatic gemm_cfg_t gemm_mode_decode(input logic [4:0] ksize,
                                                 input logic [4:0] nsize);
    gemm_cfg_t cfg;
    logic      tall;
    logic      wide;
    tall           = (ksize <= SMALL_SYS_ROWS);
    wide           = (nsize > SMALL_SYS_COLS);
    cfg.mode       = gemm_mode_t'({tall, !wide});
    cfg.if_mux_sel = !tall;
    cfg.w_mux_sel  = tall;
    return cfg;
  endfunction

endpackage

// File: rtl/gemm_tile_sequencer_if.sv
// Command/status bundle between the GEMM front end (master) and the tile
// sequencer (slave), including the input-feeder handshake.
interface gemm_tile_sequencer_if #(
  parameter int MSIZE_W = 8
) ();
  logic               start;
  logic               abort;
  logic [4:0]         ksize;
  logic [4:0]         nsize;
  logic [MSIZE_W-1:0] msize;
  logic               if_ready;

  logic               busy;
  logic               done;
  logic [1:0]         mode;
  logic               if_mux_sel;
  logic               w_mux_sel;
  logic               acc_clr;
  logic               w_load_en;
  logic [4:0]         w_row;
  logic               if_valid;
  logic [MSIZE_W-1:0] if_row;
  logic               drain_en;

  modport master (
    output start, abort, ksize, nsize, msize, if_ready,
    input  busy, done, mode, if_mux_sel, w_mux_sel, acc_clr,
           w_load_en, w_row, if_valid, if_row, drain_en
  );

  modport slave (
    input  start, abort, ksize, nsize, msize, if_ready,
    output busy, done, mode, if_mux_sel, w_mux_sel, acc_clr,
           w_load_en, w_row, if_valid, if_row, drain_en
  );
endinterface

// File: rtl/gemm_phase_counter.sv
// Loadable down-counter shared by all sequencer phases; last_o flags the
// final cycle of the loaded count.
module gemm_phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         last_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Saturates at zero so a stray enable never wraps the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (load_i)               cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == W'(1));
endmodule

// File: rtl/gemm_tile_sequencer.sv
// Steps one GEMM tile through config, weight load, input feed and drain;
// sole owner of the systolic array phase enables.
module gemm_tile_sequencer
  import gemm_tile_sequencer_pkg::*;
#(
  parameter int MSIZE_W   = 8,
  parameter int DRAIN_LAT = 31
) (
  input logic                 clk,
  input logic                 rst_n,
  gemm_tile_sequencer_if.slave bus
);
  localparam int DL_W  = $clog2(DRAIN_LAT + 1);
  localparam int SZ_W  = (MSIZE_W > 5) ? MSIZE_W : 5;
  localparam int CNT_W = (SZ_W > DL_W) ? SZ_W : DL_W;

  gemm_state_t        state_q;
  logic [4:0]         ksize_q;
  logic [4:0]         nsize_q;
  logic [MSIZE_W-1:0] msize_q;
  gemm_mode_t         mode_q;
  logic               if_mux_sel_q;
  logic               w_mux_sel_q;
  logic               done_q;
  logic               acc_clr_q;
  logic               w_load_en_q;
  logic [4:0]         w_row_q;
  logic               if_valid_q;
  logic [MSIZE_W-1:0] if_row_q;
  logic               drain_en_q;

  logic               cnt_clr;
  logic               cnt_load;
  logic               cnt_en;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_last;
  logic               kill;
  gemm_cfg_t          cfg;

  assign kill = bus.abort && (state_q != IDLE);
  assign cfg  = gemm_mode_decode(ksize_q, nsize_q);

  // Counter is reloaded on each phase boundary with the next phase's length.
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    if (kill) begin
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        CFG: begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(ksize_q);
        end
        LOAD_W: begin
          if (cnt_last) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(msize_q);
          end else begin
            cnt_en = 1'b1;
          end
        end
        FEED: begin
          if (bus.if_ready) begin
            if (cnt_last) begin
              cnt_load = 1'b1;
              cnt_val  = CNT_W'(DRAIN_LAT);
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        DRAIN:   cnt_en = 1'b1;
        default: ;
      endcase
    end
  end

  gemm_phase_counter #(.W(CNT_W)) u_phase_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .last_o     (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ksize_q      <= '0;
      nsize_q      <= '0;
      msize_q      <= '0;
      mode_q       <= MODE_WIDE;
      if_mux_sel_q <= 1'b0;
      w_mux_sel_q  <= 1'b0;
      done_q       <= 1'b0;
      acc_clr_q    <= 1'b0;
      w_load_en_q  <= 1'b0;
      w_row_q      <= '0;
      if_valid_q   <= 1'b0;
      if_row_q     <= '0;
      drain_en_q   <= 1'b0;
    end else if (kill) begin
      // Cancel drops every strobe but keeps the array configuration.
      state_q     <= IDLE;
      done_q      <= 1'b0;
      acc_clr_q   <= 1'b0;
      w_load_en_q <= 1'b0;
      if_valid_q  <= 1'b0;
      drain_en_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            ksize_q <= bus.ksize;
            nsize_q <= bus.nsize;
            msize_q <= bus.msize;
            if (bus.ksize == '0 || bus.nsize == '0 || bus.msize == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= CFG;
              acc_clr_q <= 1'b1;
            end
          end
        end
        CFG: begin
          acc_clr_q    <= 1'b0;
          mode_q       <= cfg.mode;
          if_mux_sel_q <= cfg.if_mux_sel;
          w_mux_sel_q  <= cfg.w_mux_sel;
          w_load_en_q  <= 1'b1;
          w_row_q      <= '0;
          state_q      <= LOAD_W;
        end
        LOAD_W: begin
          if (cnt_last) begin
            w_load_en_q <= 1'b0;
            if_valid_q  <= 1'b1;
            if_row_q    <= '0;
            state_q     <= FEED;
          end else begin
            w_row_q <= w_row_q + 1'b1;
          end
        end
        FEED: begin
          if (bus.if_ready) begin
            if (cnt_last) begin
              if_valid_q <= 1'b0;
              drain_en_q <= 1'b1;
              state_q    <= DRAIN;
            end else begin
              if_row_q <= if_row_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (cnt_last) begin
            drain_en_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.mode       = mode_q;
  assign bus.if_mux_sel = if_mux_sel_q;
  assign bus.w_mux_sel  = w_mux_sel_q;
  assign bus.acc_clr    = acc_clr_q;
  assign bus.w_load_en  = w_load_en_q;
  assign bus.w_row      = w_row_q;
  assign bus.if_valid   = if_valid_q;
  assign bus.if_row     = if_row_q;
  assign bus.drain_en   = drain_en_q;
endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Scenario bench for gemm_tile_sequencer: expected row indices are queued at
// start and consumed as the array strobes appear.
module tb_gemm_tile_sequencer;
  import gemm_tile_sequencer_pkg::*;

  localparam int MSIZE_W   = 8;
  localparam int DRAIN_LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   wq[$];
  int   fq[$];

  gemm_tile_sequencer_if #(.MSIZE_W(MSIZE_W)) bus ();

  gemm_tile_sequencer #(.MSIZE_W(MSIZE_W), .DRAIN_LAT(DRAIN_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Caller must be at a negedge. Drives start now; returns at the negedge after done.
  task automatic run_tile(input int k, input int n, input int m,
                          input int stall_after, input int stall_len,
                          input int restart_at, input bit abort_on_start,
                          output int lat, output int c_clr, output int c_wl,
                          output int c_iv, output int c_dr);
    int  xfers, stalls, strobes, exp_v;
    bit  fin;
    lat = -1; c_clr = 0; c_wl = 0; c_iv = 0; c_dr = 0;
    xfers = 0; stalls = 0; fin = 1'b0;
    wq.delete(); fq.delete();
    if (k != 0 && n != 0 && m != 0) begin
      for (int i = 0; i < k; i++) wq.push_back(i);
      for (int i = 0; i < m; i++) fq.push_back(i);
    end
    bus.start = 1'b1; bus.abort = abort_on_start; bus.if_ready = 1'b1;
    bus.ksize = 5'(k); bus.nsize = 5'(n); bus.msize = MSIZE_W'(m);
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      @(negedge clk);
      bus.abort = 1'b0;
      bus.start = (cyc == restart_at);
      if (cyc == restart_at) begin
        bus.ksize = 5'd1; bus.nsize = 5'd1; bus.msize = MSIZE_W'(1);
      end
      strobes = int'(bus.acc_clr) + int'(bus.w_load_en) + int'(bus.if_valid) + int'(bus.drain_en);
      checks++;
      if (strobes > 1) begin
        failures++;
        $display("FAIL phase_excl cyc=%0d got=%0d strobes required<=1", cyc, strobes);
      end
      c_clr += int'(bus.acc_clr);
      c_dr  += int'(bus.drain_en);
      if (bus.w_load_en) begin
        c_wl++;
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL w_row_extra cyc=%0d got=%0d required=none", cyc, bus.w_row);
        end else begin
          exp_v = wq.pop_front();
          if (bus.w_row !== 5'(exp_v)) begin
            failures++;
            $display("FAIL w_row cyc=%0d got=%0d required=%0d", cyc, bus.w_row, exp_v);
          end
        end
      end
      if (bus.if_valid && xfers == stall_after && stalls < stall_len) begin
        bus.if_ready = 1'b0;
        stalls++;
      end else begin
        bus.if_ready = 1'b1;
      end
      if (bus.if_valid) begin
        c_iv++;
        checks++;
        if (fq.size() == 0) begin
          failures++;
          $display("FAIL if_row_extra cyc=%0d got=%0d required=none", cyc, bus.if_row);
        end else begin
          if (bus.if_row !== MSIZE_W'(fq[0])) begin
            failures++;
            $display("FAIL if_row cyc=%0d got=%0d required=%0d", cyc, bus.if_row, fq[0]);
          end
          if (bus.if_ready) begin
            void'(fq.pop_front());
            xfers++;
          end
        end
      end
      if (bus.done) begin
        lat = cyc;
        fin = 1'b1;
        checks++;
        if (bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_on_done got=%0b required=1", bus.busy);
        end
      end
    end
    bus.if_ready = 1'b1;
    checks++;
    if (wq.size() != 0 || fq.size() != 0) begin
      failures++;
      $display("FAIL rows_left got=%0d/%0d required=0/0", wq.size(), fq.size());
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_done got busy=%0b done=%0b required=0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0; bus.if_ready = 1'b1;
    bus.ksize = '0; bus.nsize = '0; bus.msize = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.mode, bus.if_mux_sel, bus.w_mux_sel, bus.acc_clr,
         bus.w_load_en, bus.w_row, bus.if_valid, bus.if_row, bus.drain_en} !== '0) begin
      failures++;
      $display("FAIL reset_values got busy=%0b done=%0b mode=%0d w_row=%0d if_row=%0d required=all 0",
               bus.busy, bus.done, bus.mode, bus.w_row, bus.if_row);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%0b required=0", bus.busy);
    end
  endtask

  task automatic test_basic();
    int lat, c_clr, c_wl, c_iv, c_dr;
    run_tile(12, 4, 3, -1, 0, -1, 1'b0, lat, c_clr, c_wl, c_iv, c_dr);
    checks++; if (lat !== 21) begin failures++; $display("FAIL basic_latency got=%0d required=21", lat); end
    checks++; if (c_clr !== 1) begin failures++; $display("FAIL basic_acc_clr got=%0d required=1", c_clr); end
    checks++; if (c_wl !== 12) begin failures++; $display("FAIL basic_w_load got=%0d required=12", c_wl); end
    checks++; if (c_iv !== 3) begin failures++; $display("FAIL basic_if_valid got=%0d required=3", c_iv); end
    checks++; if (c_dr !== 4) begin failures++; $display("FAIL basic_drain got=%0d required=4", c_dr); end
    checks++;
    if (bus.mode !== 2'b01 || bus.if_mux_sel !== 1'b1 || bus.w_mux_sel !== 1'b0) begin
      failures++;
      $display("FAIL basic_cfg got mode=%0d if_mux=%0b w_mux=%0b required=1/1/0",
               bus.mode, bus.if_mux_sel, bus.w_mux_sel);
    end
  endtask

  task automatic test_stall();
    int lat, c_clr, c_wl, c_iv, c_dr;
    run_tile(4, 16, 2, 1, 3, -1, 1'b0, lat, c_clr, c_wl, c_iv, c_dr);
    checks++; if (lat !== 15) begin failures++; $display("FAIL stall_latency got=%0d required=15", lat); end
    checks++; if (c_iv !== 5) begin failures++; $display("FAIL stall_if_valid got=%0d required=5", c_iv); end
    checks++; if (c_wl !== 4) begin failures++; $display("FAIL stall_w_load got=%0d required=4", c_wl); end
    checks++;
    if (bus.mode !== 2'b10 || bus.if_mux_sel !== 1'b0 || bus.w_mux_sel !== 1'b1) begin
      failures++;
      $display("FAIL stall_cfg got mode=%0d if_mux=%0b w_mux=%0b required=2/0/1",
               bus.mode, bus.if_mux_sel, bus.w_mux_sel);
    end
  endtask

  task automatic test_mode_sweep();
    int         ks[4]    = '{8, 8, 9, 9};
    int         ns[4]    = '{8, 9, 8, 9};
    logic [1:0] exp_m[4] = '{2'b11, 2'b10, 2'b01, 2'b00};
    int lat, c_clr, c_wl, c_iv, c_dr;
    for (int i = 0; i < 4; i++) begin
      run_tile(ks[i], ns[i], 1, -1, 0, -1, 1'b0, lat, c_clr, c_wl, c_iv, c_dr);
      checks++;
      if (bus.mode !== exp_m[i] || bus.if_mux_sel !== !exp_m[i][1] || bus.w_mux_sel !== exp_m[i][1]) begin
        failures++;
        $display("FAIL sweep_mode k=%0d n=%0d got mode=%0d if_mux=%0b w_mux=%0b required mode=%0d",
                 ks[i], ns[i], bus.mode, bus.if_mux_sel, bus.w_mux_sel, exp_m[i]);
      end
      checks++;
      if (lat !== ks[i] + 1 + DRAIN_LAT + 2) begin
        failures++;
        $display("FAIL sweep_latency k=%0d got=%0d required=%0d", ks[i], lat, ks[i] + 1 + DRAIN_LAT + 2);
      end
    end
  endtask

  task automatic test_zero_size();
    int ks[3] = '{0, 5, 5};
    int ns[3] = '{5, 0, 5};
    int ms[3] = '{5, 5, 0};
    int lat, c_clr, c_wl, c_iv, c_dr;
    for (int i = 0; i < 3; i++) begin
      run_tile(ks[i], ns[i], ms[i], -1, 0, -1, 1'b0, lat, c_clr, c_wl, c_iv, c_dr);
      checks++;
      if (lat !== 1) begin failures++; $display("FAIL zero_latency case=%0d got=%0d required=1", i, lat); end
      checks++;
      if (c_clr + c_wl + c_iv + c_dr !== 0) begin
        failures++;
        $display("FAIL zero_strobes case=%0d got=%0d required=0", i, c_clr + c_wl + c_iv + c_dr);
      end
      checks++;
      if (bus.mode !== 2'b00 || bus.if_mux_sel !== 1'b1 || bus.w_mux_sel !== 1'b0) begin
        failures++;
        $display("FAIL zero_cfg_kept case=%0d got mode=%0d required=0", i, bus.mode);
      end
    end
  endtask

  task automatic test_abort();
    int lat, c_clr, c_wl, c_iv, c_dr, nwl;
    bit aborted;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_idle got busy=%0b required=0", bus.busy); end

    bus.start = 1'b1; bus.ksize = 5'd6; bus.nsize = 5'd12; bus.msize = MSIZE_W'(3);
    nwl = 0; aborted = 1'b0;
    for (int cyc = 1; cyc <= 40 && !aborted; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.w_load_en) nwl++;
      if (nwl == 3) begin
        checks++;
        if (bus.w_row !== 5'd2) begin failures++; $display("FAIL abort_w_row got=%0d required=2", bus.w_row); end
        bus.abort = 1'b1;
        aborted = 1'b1;
      end
    end
    checks++;
    if (!aborted) begin failures++; $display("FAIL abort_timeout got w_loads=%0d required=3", nwl); end
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.acc_clr, bus.w_load_en, bus.if_valid, bus.drain_en} !== 6'b0) begin
      failures++;
      $display("FAIL abort_drop got busy=%0b done=%0b wl=%0b iv=%0b dr=%0b required=0",
               bus.busy, bus.done, bus.w_load_en, bus.if_valid, bus.drain_en);
    end
    checks++;
    if (bus.mode !== 2'b10 || bus.if_mux_sel !== 1'b0 || bus.w_mux_sel !== 1'b1) begin
      failures++;
      $display("FAIL abort_cfg_kept got mode=%0d required=2", bus.mode);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done got done=%0b busy=%0b required=0/0", bus.done, bus.busy);
    end
    // Restart mid-tile is a start while busy and must be ignored.
    run_tile(3, 4, 2, -1, 0, 4, 1'b0, lat, c_clr, c_wl, c_iv, c_dr);
    checks++; if (lat !== 11) begin failures++; $display("FAIL abort_restart_latency got=%0d required=11", lat); end
    checks++; if (c_wl !== 3) begin failures++; $display("FAIL busy_start_ignored got w_loads=%0d required=3", c_wl); end
    run_tile(2, 2, 2, -1, 0, -1, 1'b1, lat, c_clr, c_wl, c_iv, c_dr);
    checks++; if (lat !== 10) begin failures++; $display("FAIL start_beats_abort got=%0d required=10", lat); end
    checks++; if (bus.mode !== 2'b11) begin failures++; $display("FAIL start_beats_abort_mode got=%0d required=3", bus.mode); end
  endtask

  task automatic test_reset_mid();
    int lat, c_clr, c_wl, c_iv, c_dr;
    bit seen;
    bus.start = 1'b1; bus.ksize = 5'd2; bus.nsize = 5'd3; bus.msize = MSIZE_W'(6);
    seen = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      seen = bus.if_valid;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rst_mid_timeout got if_valid=0 required=1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.mode, bus.if_mux_sel, bus.w_mux_sel, bus.acc_clr,
         bus.w_load_en, bus.w_row, bus.if_valid, bus.if_row, bus.drain_en} !== '0) begin
      failures++;
      $display("FAIL rst_mid_values got busy=%0b mode=%0d iv=%0b if_row=%0d required=all 0",
               bus.busy, bus.mode, bus.if_valid, bus.if_row);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_tile(2, 3, 2, -1, 0, -1, 1'b0, lat, c_clr, c_wl, c_iv, c_dr);
    checks++; if (lat !== 10) begin failures++; $display("FAIL rst_mid_latency got=%0d required=10", lat); end
    checks++; if (bus.mode !== 2'b11) begin failures++; $display("FAIL rst_mid_mode got=%0d required=3", bus.mode); end
  endtask

  task automatic test_back_to_back();
    int lat, c_clr, c_wl, c_iv, c_dr;
    run_tile(1, 1, 1, -1, 0, -1, 1'b0, lat, c_clr, c_wl, c_iv, c_dr);
    checks++; if (lat !== 8) begin failures++; $display("FAIL b2b_first got=%0d required=8", lat); end
    run_tile(20, 30, 5, -1, 0, -1, 1'b0, lat, c_clr, c_wl, c_iv, c_dr);
    checks++; if (lat !== 31) begin failures++; $display("FAIL b2b_second got=%0d required=31", lat); end
    checks++; if (bus.mode !== 2'b00) begin failures++; $display("FAIL b2b_mode got=%0d required=0", bus.mode); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_mode_sweep();
    test_zero_size();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
